// File: rtl/alu_cmd_ctrl_if.sv
// Command and response channels between the instruction front-end and alu_cmd_ctrl.
// The front-end is the master: it issues commands and consumes responses.
interface alu_cmd_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_opcode;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic        rsp_err;

   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_err
   );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Command-side controller for the power-gated 16-bit ALU: power-up/isolation sequencing,
// start pulse generation, operand holding and valid/ready response return.
module alu_cmd_ctrl #(
   parameter int unsigned PWR_UP_CYC   = 4,
   parameter int unsigned IDLE_TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_cmd_ctrl_if.slave bus,
   output logic          alu_pwr_en,
   output logic          iso_en,
   output logic          alu_start,
   output logic [3:0]    alu_opcode,
   output logic [15:0]   alu_a,
   output logic [15:0]   alu_b,
   input  logic          alu_busy,
   input  logic [15:0]   alu_result
);

   typedef enum logic [2:0] {
      StOff, StPwrUp, StReady, StIssue, StWait, StResp, StPwrDn
   } state_e;

   localparam logic [15:0] PwrUpLast = 16'(PWR_UP_CYC - 1);
   localparam logic [15:0] IdleLast  = 16'(IDLE_TIMEOUT - 1);

   state_e      state;
   logic [15:0] cnt;
   logic        first_wait;
   logic        accept;
   logic        legal;
   logic        muldiv;

   assign accept = bus.cmd_valid & bus.cmd_ready;
   assign legal  = ~bus.cmd_opcode[3] | (bus.cmd_opcode[3:1] == 3'b100);
   // Only legal opcodes are ever latched, so bit 3 alone marks MUL/DIV.
   assign muldiv = alu_opcode[3];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= StOff;
         cnt            <= '0;
         first_wait     <= 1'b0;
         alu_pwr_en     <= 1'b0;
         iso_en         <= 1'b1;
         alu_start      <= 1'b0;
         alu_opcode     <= '0;
         alu_a          <= '0;
         alu_b          <= '0;
         bus.cmd_ready  <= 1'b1;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_err    <= 1'b0;
         bus.rsp_result <= '0;
      end else begin
         alu_start <= 1'b0;
         unique case (state)
            StOff, StReady: begin
               if (accept) begin
                  cnt           <= '0;
                  bus.cmd_ready <= 1'b0;
                  if (!legal) begin
                     state          <= StResp;
                     bus.rsp_valid  <= 1'b1;
                     bus.rsp_result <= '0;
                     bus.rsp_err    <= 1'b1;
                  end else begin
                     alu_opcode <= bus.cmd_opcode;
                     alu_a      <= bus.cmd_a;
                     alu_b      <= bus.cmd_b;
                     if (state == StOff) begin
                        state      <= StPwrUp;
                        alu_pwr_en <= 1'b1;
                     end else begin
                        state     <= StIssue;
                        alu_start <= 1'b1;
                     end
                  end
               end else if (state == StReady && IDLE_TIMEOUT != 0) begin
                  if (cnt == IdleLast) begin
                     state         <= StPwrDn;
                     iso_en        <= 1'b1;
                     bus.cmd_ready <= 1'b0;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
            end
            StPwrUp: begin
               // Isolation drops on the same edge the start pulse is raised.
               if (cnt == PwrUpLast) begin
                  state     <= StIssue;
                  iso_en    <= 1'b0;
                  alu_start <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            StIssue: begin
               state      <= StWait;
               first_wait <= 1'b1;
            end
            StWait: begin
               first_wait <= 1'b0;
               if (!muldiv || !alu_busy) begin
                  state          <= StResp;
                  bus.rsp_valid  <= 1'b1;
                  bus.rsp_result <= alu_result;
                  // A MUL/DIV that never raised busy is reported as an error.
                  bus.rsp_err    <= muldiv & first_wait;
               end
            end
            StResp: begin
               if (bus.rsp_ready) begin
                  state         <= alu_pwr_en ? StReady : StOff;
                  cnt           <= '0;
                  bus.rsp_valid <= 1'b0;
                  bus.rsp_err   <= 1'b0;
                  bus.cmd_ready <= 1'b1;
               end
            end
            StPwrDn: begin
               state         <= StOff;
               alu_pwr_en    <= 1'b0;
               bus.cmd_ready <= 1'b1;
            end
            default: begin
               state <= StOff;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-side controller that drives the power-gated 16-bit ALU. It accepts operations over a valid/ready command channel and handles ALU power-up and isolation sequencing. It issues the single-cycle `start` pulse, holds operands through multi-cycle MUL/DIV, and returns each result over a valid/ready response channel. It sits between the instruction front-end and the ALU and is the only driver of the ALU's `alu_pwr_en`, `iso_en`, `start`, `opcode`, `A` and `B`.

## Interface
- `PWR_UP_CYC`, 4: cycles `alu_pwr_en` is high before isolation is released (≥1).
- `IDLE_TIMEOUT`, 16: consecutive idle READY cycles before auto power-down; 0 disables power-down.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_opcode`  in  4  0000–0111 simple, 1000 MUL, 1001 DIV, 1010–1111 illegal.
- `cmd_a`, `cmd_b`  in  16 each  operands.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_result`  out  16  ALU result.
- `rsp_err`  out  1  illegal opcode, or a MUL/DIV where busy never asserted.
- `alu_pwr_en`  out  1  ALU power enable.
- `iso_en`  out  1  ALU output isolation, active-high.
- `alu_start`  out  1  one-cycle start pulse.
- `alu_opcode`  out  4  ALU opcode (registered, held).
- `alu_a`, `alu_b`  out  16 each  ALU operands (registered, held).
- `alu_busy`  in  1  ALU busy.
- `alu_result`  in  16  ALU result register.

## Operation
- **States:** OFF, PWR_UP, READY, ISSUE, WAIT, RESP, PWR_DN.
- **Reset values:** state OFF; `alu_pwr_en`=0; `iso_en`=1; `alu_start`=0; `cmd_ready`=1; `rsp_valid`=0; `rsp_err`=0; `rsp_result`, `alu_opcode`, `alu_a`, `alu_b`=0.
- **Command capture:** `cmd_ready`=1 only in OFF and READY. On accept, opcode and operands are registered into `alu_opcode`/`alu_a`/`alu_b`. They are held unchanged until the next accept.
- **OFF + legal accept** → PWR_UP.
  - `alu_pwr_en`=1, `iso_en`=1 for PWR_UP_CYC cycles.
  - Then `iso_en`=0 → ISSUE.
- **READY + legal accept** → ISSUE. Power is already on and isolation is already released.
- **Illegal opcode accept (any state):** go straight to RESP with `rsp_result`=0, `rsp_err`=1. The ALU is not touched and the power state is unchanged.
- **ISSUE** (1 cycle): `alu_start`=1 → WAIT.
- **WAIT:**
  - Simple op: first WAIT cycle latches `alu_result` into `rsp_result` → RESP.
  - MUL/DIV, first WAIT cycle: `alu_busy` must be 1. If it is 0, capture `alu_result`, set `rsp_err`=1 → RESP.
  - MUL/DIV, later cycles: remain in WAIT while `alu_busy`=1. On the first cycle with `alu_busy`=0, capture `alu_result` → RESP.
- **RESP:** `rsp_valid`=1 and the response is held stable until `rsp_ready`. On handshake, go to READY if `alu_pwr_en`=1, otherwise OFF. `rsp_err` clears on handshake.
- **READY idle counter:**
  - Increments each READY cycle without an accept; cleared on entry to READY and on accept.
  - When it reaches IDLE_TIMEOUT (non-zero) → PWR_DN.
- **PWR_DN** (1 cycle): `iso_en`=1, `alu_pwr_en` still 1, `cmd_ready`=0 → OFF (`alu_pwr_en`=0).
- **Simultaneous events:**
  - An accept in the same cycle the counter would expire wins; there is no power-down.
  - `rsp_ready` without `rsp_valid` is ignored.

## Timing
Cycle 0 is the accept cycle, READY start.
- Simple op: ISSUE c1, WAIT c2, `rsp_valid` c3.
- MUL: `alu_busy` high c2–c6, capture c7, `rsp_valid` c8.
- DIV: `alu_busy` high c2–c10, capture c11, `rsp_valid` c12.
- From OFF: add PWR_UP_CYC cycles. For example, an ADD with default parameters reaches ISSUE at c5 and `rsp_valid` at c7.
- `iso_en` falls on the same edge as PWR_UP→ISSUE.
- `alu_start` is never high while `iso_en`=1 or `alu_pwr_en`=0.
- Throughput: at most one command in flight; the next accept is the cycle after the RESP handshake.
- `rst_n` low at any edge:
  - All state returns to reset values on that edge.
  - The in-flight command is dropped and no response is produced.
  - The ALU is powered off (`alu_pwr_en`=0) immediately.

## Test plan
- **Power-up ADD:** reset, then accept ADD a=0x1234, b=0x0101 from OFF. Expect `alu_pwr_en`=1 c1–, `iso_en` 1→0 at c5, `alu_start` c5 only, `rsp_valid` c7, `rsp_result`=0x1335, `rsp_err`=0.
- **MUL from READY:** a=0x0012, b=0x0003. Expect `rsp_valid` c8, `rsp_result`=0x0036; operands held stable c1–c7.
- **DIV by zero and normal DIV:** a=100, b=7 → result 14 at c12. a=5, b=0 → result 0, `rsp_err`=0.
- **Illegal opcode 1100 in READY:** expect `alu_start` never asserted, `rsp_valid` c1, result 0, `rsp_err`=1. Hold `rsp_ready`=0 for 5 cycles → response stable; a new `cmd_valid` is not accepted.
- **Idle power-down:** after a response, keep `cmd_valid`=0 for 16 READY cycles → PWR_DN with `iso_en`=1, then OFF with `alu_pwr_en`=0. Repeat with `cmd_valid` asserted on the 16th cycle → accepted, no power-down.
- **Reset mid-DIV:** assert `rst_n`=0 at c5 → next edge `alu_pwr_en`=0, `iso_en`=1, `rsp_valid`=0, `cmd_ready`=1; no response ever emitted for the dropped DIV.
